fighter_ctrl: RTL and testbench

FIGHTER_CTRL -- requirements
Module: fighter_ctrl

---
 rtl/fighter_ctrl.sv | 146 ++++++++++++++
 tb/tb_fighter_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_ctrl.sv
// Fighter character controller: one-hot action state, timed jump/punch/hitstun,
// post-punch attack lockout and single-cycle event pulses.
module fighter_ctrl #(
    parameter int unsigned CW              = 24,
    parameter int unsigned JUMP_CYCLES     = 25000000,
    parameter int unsigned PUNCH_CYCLES    = 6250000,
    parameter int unsigned COOLDOWN_CYCLES = 6250000,
    parameter int unsigned HITSTUN_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       player,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       attack_btn,
    input  logic       shield_btn,
    input  logic       hit,
    input  logic [7:0] health,
    input  logic [7:0] shield,
    output logic [8:0] action,
    output logic       attack_request,
    output logic       jump_request,
    output logic       block_event,
    output logic       jump_descending,
    output logic       busy
);

    // Counters widen past CW when a duration would not fit, so no load ever truncates.
    localparam int unsigned MAX_JP  = (JUMP_CYCLES > PUNCH_CYCLES) ? JUMP_CYCLES : PUNCH_CYCLES;
    localparam int unsigned MAX_CH  = (COOLDOWN_CYCLES > HITSTUN_CYCLES) ? COOLDOWN_CYCLES : HITSTUN_CYCLES;
    localparam int unsigned MAX_DUR = (MAX_JP > MAX_CH) ? MAX_JP : MAX_CH;
    localparam int unsigned NEED_W  = $clog2(MAX_DUR + 1);
    localparam int unsigned TW      = (CW > NEED_W) ? CW : NEED_W;

    localparam logic [TW-1:0] JUMP_LOAD  = TW'(JUMP_CYCLES - 1);
    localparam logic [TW-1:0] PUNCH_LOAD = TW'(PUNCH_CYCLES - 1);
    localparam logic [TW-1:0] HIT_LOAD   = TW'(HITSTUN_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN_CYCLES);
    localparam logic [TW-1:0] JUMP_HALF  = TW'(JUMP_CYCLES / 2);

    typedef enum logic [7:0] {
        S_WALK    = 8'b0000_0001,
        S_CROUCH  = 8'b0000_0010,
        S_SHIELD  = 8'b0000_0100,
        S_JUMP    = 8'b0000_1000,
        S_PUNCH   = 8'b0001_0000,
        S_STAND   = 8'b0010_0000,
        S_HITSTUN = 8'b0100_0000,
        S_KO      = 8'b1000_0000
    } state_t;

    state_t        state, state_nxt, pick;
    logic          dir, dir_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [TW-1:0] cooldown, cooldown_nxt, cooldown_dec;
    logic          areq_nxt, jreq_nxt, blk_nxt, desc_nxt, busy_nxt;
    logic          free_state, expired, attack_ok;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_STAND;
            dir             <= player;
            timer           <= '0;
            cooldown        <= '0;
            attack_request  <= 1'b0;
            jump_request    <= 1'b0;
            block_event     <= 1'b0;
            jump_descending <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            dir             <= dir_nxt;
            timer           <= timer_nxt;
            cooldown        <= cooldown_nxt;
            attack_request  <= areq_nxt;
            jump_request    <= jreq_nxt;
            block_event     <= blk_nxt;
            jump_descending <= desc_nxt;
            busy            <= busy_nxt;
        end
    end

    // Next-state, counter and pulse logic
    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir;
        timer_nxt    = (timer == '0) ? '0 : timer - TW'(1);
        cooldown_dec = (cooldown == '0) ? '0 : cooldown - TW'(1);
        cooldown_nxt = cooldown_dec;
        areq_nxt     = 1'b0;
        jreq_nxt     = 1'b0;
        blk_nxt      = 1'b0;
        pick         = S_STAND;

        free_state = (state == S_STAND) || (state == S_WALK) ||
                     (state == S_CROUCH) || (state == S_SHIELD);
        expired    = (timer == '0);
        // Lockout spans exactly COOLDOWN_CYCLES shown cycles after a punch ends.
        attack_ok  = (cooldown_dec == '0) && (state != S_PUNCH);

        if (down_btn)                    pick = S_CROUCH;
        else if (left_btn || right_btn)  pick = S_WALK;
        else if (shield_btn)             pick = S_SHIELD;
        else if (up_btn)                 pick = S_JUMP;
        else if (attack_btn && attack_ok) pick = S_PUNCH;

        if (free_state || state == S_JUMP) begin
            if (right_btn)     dir_nxt = 1'b0;
            else if (left_btn) dir_nxt = 1'b1;
        end

        if (state == S_KO) begin
            state_nxt = S_KO;
        end else if (health == 8'd0) begin
            state_nxt = S_KO;
        end else if (hit && state == S_SHIELD && shield != 8'd0) begin
            blk_nxt = 1'b1;
        end else if (hit) begin
            state_nxt = S_HITSTUN;
            timer_nxt = HIT_LOAD;
        end else if (free_state || expired) begin
            state_nxt = pick;
            if (pick == S_JUMP) begin
                timer_nxt = JUMP_LOAD;
                jreq_nxt  = 1'b1;
            end else if (pick == S_PUNCH) begin
                timer_nxt = PUNCH_LOAD;
                areq_nxt  = 1'b1;
            end
        end

        if (state == S_PUNCH && state_nxt != S_PUNCH) begin
            cooldown_nxt = COOL_LOAD;
        end

        desc_nxt = (state_nxt == S_JUMP) && (timer_nxt < JUMP_HALF);
        busy_nxt = (state_nxt == S_JUMP) || (state_nxt == S_PUNCH) ||
                   (state_nxt == S_HITSTUN) || (state_nxt == S_KO);
    end

    assign action = {dir, state};

endmodule

// File: tb/tb_fighter_ctrl.sv
// Bench for fighter_ctrl: directed scenarios with literal expectations plus
// randomized play compared every cycle against a behavioural model.
module tb_fighter_ctrl;

    localparam int J = 8;
    localparam int P = 4;
    localparam int C = 6;
    localparam int H = 5;

    localparam int ST_WALK = 0, ST_CROUCH = 1, ST_SHIELD = 2, ST_JUMP = 3;
    localparam int ST_PUNCH = 4, ST_STAND = 5, ST_HIT = 6, ST_KO = 7;

    logic       clk = 1'b0;
    logic       reset, player;
    logic       left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn, hit;
    logic [7:0] health, shield;
    logic [8:0] action;
    logic       attack_request, jump_request, block_event, jump_descending, busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fighter_ctrl #(
        .CW(8), .JUMP_CYCLES(J), .PUNCH_CYCLES(P),
        .COOLDOWN_CYCLES(C), .HITSTUN_CYCLES(H)
    ) dut (
        .clk(clk), .reset(reset), .player(player),
        .left_btn(left_btn), .right_btn(right_btn), .up_btn(up_btn),
        .down_btn(down_btn), .attack_btn(attack_btn), .shield_btn(shield_btn),
        .hit(hit), .health(health), .shield(shield),
        .action(action), .attack_request(attack_request),
        .jump_request(jump_request), .block_event(block_event),
        .jump_descending(jump_descending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: state index, elapsed cycles in the current timed segment,
    // and number of upcoming decisions in which attack is still locked out.
    int m_st, m_el, m_lock;
    bit m_dir, m_jr, m_ar, m_bk;
    int n_st, n_el, n_lock;
    bit n_dir, n_seg, n_done, n_free;

    function automatic int pick_free(input bit dn, lf, rt, sh, upb, atk, atk_ok);
        if (dn)            return ST_CROUCH;
        if (lf || rt)      return ST_WALK;
        if (sh)            return ST_SHIELD;
        if (upb)           return ST_JUMP;
        if (atk && atk_ok) return ST_PUNCH;
        return ST_STAND;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_st = ST_STAND; m_dir = player; m_el = 1; m_lock = 0;
            m_jr = 0; m_ar = 0; m_bk = 0;
        end else begin
            n_st   = m_st;
            n_dir  = m_dir;
            n_seg  = 0;
            n_lock = (m_lock > 0) ? m_lock - 1 : 0;
            m_bk   = 0;
            n_free = (m_st == ST_STAND || m_st == ST_WALK || m_st == ST_CROUCH || m_st == ST_SHIELD);
            n_done = (m_st == ST_JUMP && m_el == J) || (m_st == ST_PUNCH && m_el == P) ||
                     (m_st == ST_HIT && m_el == H);
            if (n_free || m_st == ST_JUMP)
                n_dir = right_btn ? 1'b0 : (left_btn ? 1'b1 : m_dir);
            if (m_st == ST_KO) begin
                n_st = ST_KO;
            end else if (health == 0) begin
                n_st = ST_KO;
            end else if (hit && m_st == ST_SHIELD && shield != 0) begin
                m_bk = 1;
            end else if (hit) begin
                n_st = ST_HIT; n_seg = 1;
            end else if (n_free || n_done) begin
                n_st  = pick_free(down_btn, left_btn, right_btn, shield_btn, up_btn, attack_btn,
                                  (m_lock == 0) && (m_st != ST_PUNCH));
                n_seg = n_done || (n_st != m_st);
            end
            if (n_st != m_st) n_seg = 1;
            if (m_st == ST_PUNCH && n_st != ST_PUNCH) n_lock = C - 1;
            m_jr   = (n_st == ST_JUMP) && n_seg;
            m_ar   = (n_st == ST_PUNCH) && n_seg;
            m_el   = n_seg ? 1 : m_el + 1;
            m_st   = n_st;
            m_dir  = n_dir;
            m_lock = n_lock;
        end
    end

    logic [8:0] exp_action;
    bit         exp_desc, exp_busy;
    always_comb begin
        exp_action = {m_dir, 8'(32'd1 << m_st)};
        exp_desc   = (m_st == ST_JUMP) && (m_el > J - J / 2);
        exp_busy   = (m_st == ST_JUMP) || (m_st == ST_PUNCH) || (m_st == ST_HIT) || (m_st == ST_KO);
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_action", 32'(action), 32'(exp_action));
            chk("m_attack_request", 32'(attack_request), 32'(m_ar));
            chk("m_jump_request", 32'(jump_request), 32'(m_jr));
            chk("m_block_event", 32'(block_event), 32'(m_bk));
            chk("m_jump_descending", 32'(jump_descending), 32'(exp_desc));
            chk("m_busy", 32'(busy), 32'(exp_busy));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    logic [15:0] v1, v2, v3;

    initial begin
        reset = 0; player = 1; left_btn = 0; right_btn = 0; up_btn = 0; down_btn = 0;
        attack_btn = 0; shield_btn = 0; hit = 0; health = 8'd100; shield = 8'd50;
        idle(2);
        chk_en = 1;
        chk("reset_action", 32'(action), 32'h120);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1;

        // Jump: 8 cycles, one request, descending on cycles 5-8
        up_btn = 1; v1 = '0; v2 = '0; v3 = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            up_btn = 0;
            v1[i-1] = action[3]; v2[i-1] = jump_descending; v3[i-1] = jump_request;
        end
        chk("jump_cycles", 32'(v1), 32'h00FF);
        chk("jump_desc", 32'(v2), 32'h00F0);
        chk("jump_req", 32'(v3), 32'h0001);
        chk("jump_end_stand", 32'(action), 32'h120);

        // Held attack: punch, 6 locked stand cycles, second punch
        attack_btn = 1; v1 = '0; v2 = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            v1[i-1] = action[4]; v2[i-1] = attack_request;
        end
        chk("punch_cycles", 32'(v1), 32'h3C0F);
        chk("punch_req", 32'(v2), 32'h0401);
        attack_btn = 0;
        idle(10);

        // Blocked hit in shield, then unblocked hit with restart
        shield_btn = 1;
        @(negedge clk);
        chk("shield_state", 32'(action[7:0]), 32'h04);
        hit = 1;
        @(negedge clk);
        hit = 0;
        chk("block_pulse", 32'(block_event), 32'h1);
        chk("block_keeps_shield", 32'(action[7:0]), 32'h04);
        @(negedge clk);
        chk("block_pulse_end", 32'(block_event), 32'h0);
        shield = 8'd0; hit = 1; v1 = '0; v2 = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            hit = (i == 3);
            v1[i-1] = action[6]; v2[i-1] = block_event;
        end
        chk("hitstun_extend", 32'(v1), 32'h00FF);
        chk("no_block_shield0", 32'(v2), 32'h0000);
        shield_btn = 0; shield = 8'd50;
        idle(3);

        // Hit during jump cycle 3
        up_btn = 1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            up_btn = 0;
            if (i == 3) chk("jump_c3", 32'(action[7:0]), 32'h08);
            if (i == 4) chk("jump_hit_abort", 32'(action[7:0]), 32'h40);
            hit = (i == 3);
        end
        idle(8);

        // Hit during punch cycle 2 with attack held
        attack_btn = 1; v1 = '0; v2 = '0; v3 = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            hit = (i == 2);
            v1[i-1] = action[4]; v2[i-1] = action[6]; v3[i-1] = attack_request;
        end
        chk("phit_punch", 32'(v1), 32'h0F03);
        chk("phit_hitstun", 32'(v2), 32'h007C);
        chk("phit_req", 32'(v3), 32'h0101);
        attack_btn = 0;
        idle(12);

        // KO during punch overrides hit; reset clears it
        attack_btn = 1;
        @(negedge clk);
        chk("ko_pre_punch", 32'(action[7:0]), 32'h10);
        health = 8'd0; hit = 1;
        @(negedge clk);
        chk("ko_state", 32'(action[7:0]), 32'h80);
        chk("ko_busy", 32'(busy), 32'h1);
        hit = 0; left_btn = 1; up_btn = 1;
        idle(3);
        chk("ko_held", 32'(action), 32'h180);
        chk("ko_no_pulse", 32'({attack_request, jump_request, block_event}), 32'h0);
        player = 0; reset = 0;
        @(negedge clk);
        chk("ko_reset", 32'(action), 32'h020);
        chk("ko_reset_busy", 32'(busy), 32'h0);
        reset = 1; health = 8'd100; left_btn = 0; up_btn = 0; attack_btn = 0;
        @(negedge clk);

        // Direction rules
        left_btn = 1;
        @(negedge clk); chk("dir_left", 32'(action), 32'h101);
        right_btn = 1;
        @(negedge clk); chk("dir_both", 32'(action), 32'h001);
        left_btn = 0; right_btn = 0;
        @(negedge clk); chk("dir_held0", 32'(action), 32'h020);
        left_btn = 1;
        @(negedge clk); chk("dir_left2", 32'(action), 32'h101);
        left_btn = 0;
        @(negedge clk); chk("dir_held1", 32'(action), 32'h120);
        hit = 1;
        @(negedge clk); chk("dir_hitstun", 32'(action), 32'h140);
        hit = 0; right_btn = 1;
        @(negedge clk); chk("dir_frozen", 32'(action), 32'h140);
        right_btn = 0;
        idle(6);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            reset      = !(($urandom_range(0, 199) == 0) || (m_st == ST_KO && $urandom_range(0, 7) == 0));
            player     = 1'($urandom_range(0, 1));
            left_btn   = ($urandom_range(0, 3) == 0);
            right_btn  = ($urandom_range(0, 4) == 0);
            up_btn     = ($urandom_range(0, 4) == 0);
            down_btn   = ($urandom_range(0, 7) == 0);
            attack_btn = ($urandom_range(0, 2) == 0);
            shield_btn = ($urandom_range(0, 3) == 0);
            hit        = ($urandom_range(0, 11) == 0);
            health     = ($urandom_range(0, 299) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            shield     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
